// File: rtl/cpu_vram_readback.sv
// cpu_vram_readback: answers Z80 memory reads inside the back-VRAM window
// with the byte stored in back VRAM, and yields the VRAM bus to the buffer
// copier whenever a copy is running.
// Optional feature macro: READBACK_WAIT_EN. When defined, the CPU is stalled
// through /WAIT until data is ready, and a read that meets a running copy
// waits for it. When undefined, /WAIT is never asserted and such a read
// returns 8'hFF without touching VRAM.
module cpu_vram_readback #(
    parameter logic [15:0] BASE_ADDR = 16'h8000,
    parameter int          VRAM_AW   = 13,
    parameter int          RD_WAIT   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [15:0]        cpu_addr_i,
    input  logic               cpu_rd_i,
    input  logic               cpu_mreq_i,
    input  logic               copy_in_progress_i,
    input  logic [7:0]         back_vram_data_i,
    output logic [VRAM_AW-1:0] back_vram_addr_o,
    output logic               back_vram_rd_low_o,
    output logic               back_vram_addr_en_o,
    output logic [7:0]         cpu_data_out_o,
    output logic               cpu_data_oe_o,
    output logic               cpu_wait_n_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        ACCESS = 2'd2,
        DRIVE  = 2'd3
    } state_t;

    // Last value of the access counter; the VRAM byte is latched on this cycle.
    localparam logic [3:0] LAST = 4'(RD_WAIT - 1);

    logic               rd_s1_q, rd_s2_q;
    logic               mreq_s1_q, mreq_s2_q;
    logic               strb_q;
    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [7:0]         data_q, data_d;

    logic strb;
    logic start;
    logic hit;
    logic rd_low;
    logic addr_en;
    logic oe;
    logic wait_n;

    // Synchronised strobe is active while both /MREQ and /RD are low;
    // a new transaction starts on its rising edge only.
    assign strb  = ~mreq_s2_q & ~rd_s2_q;
    assign start = strb & ~strb_q;
    assign hit   = (cpu_addr_i[15:VRAM_AW] == BASE_ADDR[15:VRAM_AW]);

    // Two-stage synchronisers for the asynchronous Z80 strobes plus the
    // strobe history used for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_s1_q   <= 1'b1;
            rd_s2_q   <= 1'b1;
            mreq_s1_q <= 1'b1;
            mreq_s2_q <= 1'b1;
            strb_q    <= 1'b0;
        end else begin
            rd_s1_q   <= cpu_rd_i;
            rd_s2_q   <= rd_s1_q;
            mreq_s1_q <= cpu_mreq_i;
            mreq_s2_q <= mreq_s1_q;
            strb_q    <= strb;
        end
    end

    // FSM state, access counter, latched VRAM address and returned byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic and bus outputs; a copy in progress always wins the
    // VRAM bus, and a dropped CPU strobe always aborts back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_low  = 1'b1;
        addr_en = 1'b0;
        oe      = 1'b0;
        wait_n  = 1'b1;
        case (state_q)
            IDLE: begin
                if (start && hit) begin
                    addr_d = cpu_addr_i[VRAM_AW-1:0];
                    cnt_d  = 4'd0;
`ifdef READBACK_WAIT_EN
                    state_d = copy_in_progress_i ? HOLD : ACCESS;
`else
                    if (copy_in_progress_i) begin
                        data_d  = 8'hFF;
                        state_d = DRIVE;
                    end else begin
                        state_d = ACCESS;
                    end
`endif
                end
            end
            HOLD: begin
`ifdef READBACK_WAIT_EN
                wait_n = 1'b0;
`endif
                if (!strb) begin
                    state_d = IDLE;
                end else if (!copy_in_progress_i) begin
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rd_low  = 1'b0;
                addr_en = 1'b1;
`ifdef READBACK_WAIT_EN
                wait_n  = 1'b0;
`endif
                if (!strb) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (copy_in_progress_i) begin
                    cnt_d   = 4'd0;
`ifdef READBACK_WAIT_EN
                    state_d = HOLD;
`else
                    data_d  = 8'hFF;
                    state_d = DRIVE;
`endif
                end else if (cnt_q == LAST) begin
                    cnt_d   = 4'd0;
                    data_d  = back_vram_data_i;
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DRIVE: begin
                oe = 1'b1;
                if (!strb) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign back_vram_addr_o    = addr_q;
    assign back_vram_rd_low_o  = rd_low;
    assign back_vram_addr_en_o = addr_en;
    assign cpu_data_out_o      = data_q;
    assign cpu_data_oe_o       = oe;
    assign cpu_wait_n_o        = wait_n;
    assign busy_o              = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_vram_readback.sv
// Directed bench for cpu_vram_readback with a small back-VRAM model.
// Builds with or without READBACK_WAIT_EN; expectations follow the macro.
module tb_cpu_vram_readback;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_mreq;
    logic        copy;
    logic [7:0]  vram_data;
    logic [12:0] vram_addr;
    logic        rd_low;
    logic        addr_en;
    logic [7:0]  data_out;
    logic        oe;
    logic        wait_n;
    logic        busy;

    logic [7:0]  mem [0:8191];

    int checks = 0;
    int errors = 0;

    // activity monitor, sampled 1 time unit after each rising edge
    int rd_low_cnt = 0;
    int ae_cnt     = 0;
    int oe_cnt     = 0;
    int busy_cnt   = 0;

`ifdef READBACK_WAIT_EN
    localparam logic WAIT_LOW = 1'b0;
`else
    localparam logic WAIT_LOW = 1'b1;
`endif

    cpu_vram_readback #(
        .BASE_ADDR(16'h8000),
        .VRAM_AW  (13),
        .RD_WAIT  (2)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cpu_addr_i         (cpu_addr),
        .cpu_rd_i           (cpu_rd),
        .cpu_mreq_i         (cpu_mreq),
        .copy_in_progress_i (copy),
        .back_vram_data_i   (vram_data),
        .back_vram_addr_o   (vram_addr),
        .back_vram_rd_low_o (rd_low),
        .back_vram_addr_en_o(addr_en),
        .cpu_data_out_o     (data_out),
        .cpu_data_oe_o      (oe),
        .cpu_wait_n_o       (wait_n),
        .busy_o             (busy)
    );

    assign vram_data = mem[vram_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #1;
        if (rd_low == 1'b0) rd_low_cnt++;
        if (addr_en) ae_cnt++;
        if (oe) oe_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        rd_low_cnt = 0;
        ae_cnt     = 0;
        oe_cnt     = 0;
        busy_cnt   = 0;
    endtask

    // assert /MREQ and /RD with the address at a falling edge
    task automatic cpu_read(input logic [15:0] a);
        @(negedge clk);
        cpu_addr = a;
        cpu_mreq = 1'b0;
        cpu_rd   = 1'b0;
    endtask

    task automatic cpu_release();
        @(negedge clk);
        cpu_mreq = 1'b1;
        cpu_rd   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_oe(input int max);
        int n;
        n = 0;
        while (!oe && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("oe_timeout", 32'(oe), 32'h1);
    endtask

    initial begin
        int wait_bad;
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7 + 3);
        mem[13'h0123] = 8'h5A;
        mem[13'h1FFF] = 8'hC3;
        mem[13'h0040] = 8'h3C;
        mem[13'h0005] = 8'h11;
        mem[13'h0300] = 8'h96;

        rst      = 1'b1;
        cpu_addr = 16'h0000;
        cpu_rd   = 1'b1;
        cpu_mreq = 1'b1;
        copy     = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_oe", 32'(oe), 32'h0);
        check("rst_wait", 32'(wait_n), 32'h1);
        check("rst_addr", 32'(vram_addr), 32'h0);
        check("rst_rdlow", 32'(rd_low), 32'h1);
        check("rst_addren", 32'(addr_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: plain read at 0x8123
        clear_mon();
        cpu_read(16'h8123);
        repeat (2) @(posedge clk);
        #1;
        check("t1_rdlow_lat2", 32'(rd_low), 32'h1);
        @(posedge clk);
        #1;
        check("t1_rdlow_lat3", 32'(rd_low), 32'h0);
        check("t1_addr", 32'(vram_addr), 32'h0123);
        check("t1_addren", 32'(addr_en), 32'h1);
        check("t1_wait", 32'(wait_n), 32'(WAIT_LOW));
        check("t1_busy", 32'(busy), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("t1_oe", 32'(oe), 32'h1);
        check("t1_data", 32'(data_out), 32'h5A);
        check("t1_wait_drive", 32'(wait_n), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("t1_oe_hold", 32'(oe), 32'h1);
        check("t1_data_hold", 32'(data_out), 32'h5A);
        cpu_release();
        check("t1_rdlow_width", 32'(rd_low_cnt), 32'd2);
        check("t1_oe_off", 32'(oe), 32'h0);
        check("t1_busy_off", 32'(busy), 32'h0);

        // 2: misses just below and just above the window
        clear_mon();
        cpu_read(16'h7FFF);
        repeat (8) @(posedge clk);
        cpu_release();
        cpu_read(16'hA000);
        repeat (8) @(posedge clk);
        cpu_release();
        check("t2_rdlow", 32'(rd_low_cnt), 32'd0);
        check("t2_addren", 32'(ae_cnt), 32'd0);
        check("t2_oe", 32'(oe_cnt), 32'd0);
        check("t2_busy", 32'(busy_cnt), 32'd0);

        // 3: copy already running when the read starts
        clear_mon();
        @(negedge clk);
        copy = 1'b1;
        cpu_read(16'h8040);
        repeat (3) @(posedge clk);
        #1;
        check("t3_busy", 32'(busy), 32'h1);
        wait_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (wait_n !== WAIT_LOW) wait_bad++;
        end
        check("t3_wait_hold", 32'(wait_bad), 32'd0);
        check("t3_no_rdlow", 32'(rd_low_cnt), 32'd0);
`ifdef READBACK_WAIT_EN
        check("t3_no_oe", 32'(oe_cnt), 32'd0);
        @(negedge clk);
        copy = 1'b0;
        wait_oe(10);
        check("t3_data", 32'(data_out), 32'h3C);
        check("t3_rdlow_width", 32'(rd_low_cnt), 32'd2);
`else
        check("t3_oe", 32'(oe), 32'h1);
        check("t3_data_ff", 32'(data_out), 32'hFF);
        @(negedge clk);
        copy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t3_data_ff_hold", 32'(data_out), 32'hFF);
        check("t3_no_rdlow_end", 32'(rd_low_cnt), 32'd0);
`endif
        cpu_release();

        // 4: /RD released so the synchronised strobe drops one cycle into ACCESS
        clear_mon();
        cpu_read(16'h8200);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cpu_rd   = 1'b1;
        cpu_mreq = 1'b1;
        @(posedge clk);
        #1;
        check("t4_access", 32'(rd_low), 32'h0);
        repeat (5) @(posedge clk);
        #1;
        check("t4_no_oe", 32'(oe_cnt), 32'd0);
        check("t4_idle", 32'(busy), 32'h0);
        check("t4_wait", 32'(wait_n), 32'h1);
        cpu_read(16'h9FFF);
        wait_oe(12);
        check("t4_addr2", 32'(vram_addr), 32'h1FFF);
        check("t4_data2", 32'(data_out), 32'hC3);
        cpu_release();

        // 5: reset while driving the CPU bus
        cpu_read(16'h8005);
        wait_oe(12);
        check("t5_data", 32'(data_out), 32'h11);
        @(negedge clk);
        rst      = 1'b1;
        cpu_rd   = 1'b1;
        cpu_mreq = 1'b1;
        @(posedge clk);
        #1;
        check("t5_oe", 32'(oe), 32'h0);
        check("t5_rdlow", 32'(rd_low), 32'h1);
        check("t5_wait", 32'(wait_n), 32'h1);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_dataout", 32'(data_out), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t5_stay_idle", 32'(busy), 32'h0);

        // 6: copy starts while VRAM is being read
        clear_mon();
        cpu_read(16'h8300);
        repeat (3) @(posedge clk);
        #1;
        check("t6_access", 32'(rd_low), 32'h0);
        @(negedge clk);
        copy = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rdlow_rel", 32'(rd_low), 32'h1);
        check("t6_addren_rel", 32'(addr_en), 32'h0);
`ifdef READBACK_WAIT_EN
        check("t6_hold_wait", 32'(wait_n), 32'h0);
        check("t6_hold_oe", 32'(oe), 32'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        copy = 1'b0;
        wait_oe(10);
        check("t6_data", 32'(data_out), 32'h96);
        check("t6_addr", 32'(vram_addr), 32'h0300);
`else
        check("t6_oe", 32'(oe), 32'h1);
        check("t6_data_ff", 32'(data_out), 32'hFF);
        @(negedge clk);
        copy = 1'b0;
`endif
        cpu_release();
        check("t6_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
